// File: rtl/pipelined_adder.sv
// pipelined_adder: two's-complement adder/subtractor whose carry chain is split into STAGES
// registered segments, with valid/ready flow control and flush. Macro PIPELINED_ADDER_SAT_EN saturates on overflow.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int SKEW  = (STAGES > 1) ? STAGES - 1 : 1;

   logic             w_advance;
   logic             w_accept;

   logic [WIDTH-1:0] w_aIn   [STAGES];
   logic [WIDTH-1:0] w_bIn   [STAGES];
   logic [WIDTH-1:0] w_sIn   [STAGES];
   logic             w_cIn   [STAGES];
   logic             w_vIn   [STAGES];

   logic [WIDTH-1:0] r_a     [SKEW];
   logic [WIDTH-1:0] r_b     [SKEW];
   logic [WIDTH-1:0] r_s     [SKEW];
   logic             r_carry [SKEW];
   logic             r_valid [SKEW];

   logic [WIDTH-1:0] r_sum;
   logic             r_cOut;
   logic             r_ovf;
   logic             r_outValid;

   // The whole pipeline moves in lockstep; a flush cycle never accepts a beat.
   assign w_advance = !r_outValid || out_ready;
   assign in_ready  = w_advance && !flush;
   assign w_accept  = in_valid && in_ready;

   assign w_aIn[0] = a;
   assign w_bIn[0] = sub ? ~b : b;
   assign w_cIn[0] = sub ? 1'b1 : c_in;
   assign w_sIn[0] = '0;
   assign w_vIn[0] = w_accept;

   assign out_valid = r_outValid;
   assign sum       = r_sum;
   assign c_out     = r_cOut;
   assign ovf       = r_ovf;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK-1:0] w_chunk;
      logic             w_co;
      logic [WIDTH-1:0] w_sOut;

      assign {w_co, w_chunk} = {1'b0, w_aIn[k][k*CHUNK +: CHUNK]}
                             + {1'b0, w_bIn[k][k*CHUNK +: CHUNK]}
                             + {{CHUNK{1'b0}}, w_cIn[k]};

      always_comb begin
         w_sOut                     = w_sIn[k];
         w_sOut[k*CHUNK +: CHUNK]   = w_chunk;
      end

      if (k < STAGES - 1) begin : g_mid
         // Operands ride along (skewed) until their chunk is consumed; finished chunks ride along too.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid[k] <= 1'b0;
               r_a[k]     <= '0;
               r_b[k]     <= '0;
               r_s[k]     <= '0;
               r_carry[k] <= 1'b0;
            end else begin
               if (flush) begin
                  r_valid[k] <= 1'b0;
               end else if (w_advance) begin
                  r_valid[k] <= w_vIn[k];
               end
               if (w_advance) begin
                  r_a[k]     <= w_aIn[k];
                  r_b[k]     <= w_bIn[k];
                  r_s[k]     <= w_sOut;
                  r_carry[k] <= w_co;
               end
            end
         end

         assign w_aIn[k+1] = r_a[k];
         assign w_bIn[k+1] = r_b[k];
         assign w_sIn[k+1] = r_s[k];
         assign w_cIn[k+1] = r_carry[k];
         assign w_vIn[k+1] = r_valid[k];
      end else begin : g_last
         logic             w_msbCarryIn;
         logic             w_ovf;
         logic [WIDTH-1:0] w_result;

         // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
         assign w_msbCarryIn = w_aIn[k][WIDTH-1] ^ w_bIn[k][WIDTH-1] ^ w_sOut[WIDTH-1];
         assign w_ovf        = w_msbCarryIn ^ w_co;

`ifdef PIPELINED_ADDER_SAT_EN
         always_comb begin
            w_result = w_sOut;
            if (w_ovf) begin
               w_result = w_aIn[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
            end
         end
`else
         assign w_result = w_sOut;
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_outValid <= 1'b0;
               r_sum      <= '0;
               r_cOut     <= 1'b0;
               r_ovf      <= 1'b0;
            end else begin
               if (flush) begin
                  r_outValid <= 1'b0;
               end else if (w_advance) begin
                  r_outValid <= w_vIn[k];
               end
               if (w_advance) begin
                  r_sum  <= w_result;
                  r_cOut <= w_co;
                  r_ovf  <= w_ovf;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed self-checking bench for pipelined_adder at WIDTH=32, STAGES=4.
// Expected values are hand-computed; define PIPELINED_ADDER_SAT_EN to check the saturating build.
module tb_pipelined_adder;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             c_in = 1'b0;
   logic             sub = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;

   int checks   = 0;
   int failures = 0;

   pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .c_out(c_out), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat for one cycle, then waits (bounded) until a result shows up.
   task automatic issueBeat(input logic [WIDTH-1:0] aV, input logic [WIDTH-1:0] bV,
                            input logic cinV, input logic subV, output int lat);
      a = aV; b = bV; c_in = cinV; sub = subV; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== 32'h0 || c_out !== 1'b0 || ovf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got valid=%b sum=%h c=%b ovf=%b, want 0/0/0/0", out_valid, sum, c_out, ovf);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_in_ready: got %b, want 1", in_ready);
      end
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_carry();
      int lat;
      issueBeat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
      checks++;
      if (lat !== STAGES) begin
         failures++;
         $display("[TB] FAIL carry_latency: got %0d, want %0d", lat, STAGES);
      end
      checks++;
      if (sum !== 32'h0 || c_out !== 1'b1 || ovf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL carry_result: got sum=%h c=%b ovf=%b, want 00000000/1/0", sum, c_out, ovf);
      end
      tick();
   endtask

   task automatic test_overflow();
      int lat;
      logic [WIDTH-1:0] expSum;
`ifdef PIPELINED_ADDER_SAT_EN
      expSum = 32'h7FFF_FFFF;
`else
      expSum = 32'h8000_0000;
`endif
      issueBeat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
      checks++;
      if (sum !== expSum || c_out !== 1'b0 || ovf !== 1'b1 || lat !== STAGES) begin
         failures++;
         $display("[TB] FAIL overflow_pos: got sum=%h c=%b ovf=%b lat=%0d, want %h/0/1/%0d", sum, c_out, ovf, lat, expSum, STAGES);
      end
      tick();
`ifdef PIPELINED_ADDER_SAT_EN
      expSum = 32'h8000_0000;
`else
      expSum = 32'h7FFF_FFFF;
`endif
      issueBeat(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
      checks++;
      if (sum !== expSum || c_out !== 1'b1 || ovf !== 1'b1) begin
         failures++;
         $display("[TB] FAIL overflow_neg: got sum=%h c=%b ovf=%b, want %h/1/1", sum, c_out, ovf, expSum);
      end
      tick();
   endtask

   task automatic test_subtract();
      int lat;
      issueBeat(32'd5, 32'd7, 1'b1, 1'b1, lat);
      checks++;
      if (sum !== 32'hFFFF_FFFE || c_out !== 1'b0 || ovf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL sub_borrow: got sum=%h c=%b ovf=%b, want fffffffe/0/0", sum, c_out, ovf);
      end
      tick();
      issueBeat(32'd7, 32'd5, 1'b0, 1'b1, lat);
      checks++;
      if (sum !== 32'h0000_0002 || c_out !== 1'b1 || ovf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL sub_noborrow: got sum=%h c=%b ovf=%b, want 00000002/1/0", sum, c_out, ovf);
      end
      tick();
      issueBeat(32'h0000_00F1, 32'h0000_010E, 1'b1, 1'b0, lat);
      checks++;
      if (sum !== 32'h0000_0200 || c_out !== 1'b0 || ovf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL add_cin: got sum=%h c=%b ovf=%b, want 00000200/0/0", sum, c_out, ovf);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int got = 0;
      int stallLeft = 0;
      int lowCount = 0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         in_valid  = (sent < 8);
         a         = sent;
         b         = sent * 32'h100;
         c_in      = 1'b0;
         sub       = 1'b0;
         out_ready = (stallLeft == 0);
         #1;
         if (in_ready !== 1'b1) lowCount++;
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (sum !== got * 32'h101) begin
               failures++;
               $display("[TB] FAIL stream_result[%0d]: got %h, want %h", got, sum, got * 32'h101);
            end
            got++;
            if (got == 2) stallLeft = 3;
         end else if (!out_ready && stallLeft > 0) begin
            stallLeft--;
         end
         if (in_valid && in_ready === 1'b1) sent++;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != 8) begin
         failures++;
         $display("[TB] FAIL stream_count: got %0d results, want 8", got);
      end
      checks++;
      if (lowCount != 3) begin
         failures++;
         $display("[TB] FAIL stream_in_ready_low: got %0d cycles, want 3", lowCount);
      end
      for (int i = 0; i < STAGES + 1; i++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stream_extra[%0d]: got valid=%b sum=%h, want valid 0", i, out_valid, sum);
         end
         tick();
      end
   endtask

   task automatic test_flush();
      int seen = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = 32'h1000 + i; b = 32'h1; sub = 1'b0; c_in = 1'b0;
         tick();
      end
      flush = 1'b1; a = 32'hDEAD; b = 32'h1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL flush_in_ready: got %b, want 0", in_ready);
      end
      tick();
      flush = 1'b0; a = 32'h10; b = 32'h20;
      tick();
      in_valid = 1'b0;
      for (int i = 1; i < STAGES; i++) begin
         if (out_valid !== 1'b0) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("[TB] FAIL flush_stale: got %0d stale results, want 0", seen);
      end
      checks++;
      if (out_valid !== 1'b1 || sum !== 32'h30) begin
         failures++;
         $display("[TB] FAIL flush_next_beat: got valid=%b sum=%h, want 1/00000030", out_valid, sum);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL flush_tail: got valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = 32'h11 + i; b = 32'h22; sub = 1'b0; c_in = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || sum !== 32'h33) begin
         failures++;
         $display("[TB] FAIL rstmid_pre: got valid=%b sum=%h, want 1/00000033", out_valid, sum);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== 32'h0 || c_out !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rstmid_outputs: got valid=%b sum=%h c=%b ovf=%b rdy=%b, want 0/0/0/0/1", out_valid, sum, c_out, ovf, in_ready);
      end
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      for (int i = 0; i < STAGES; i++) begin
         if (out_valid !== 1'b0) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("[TB] FAIL rstmid_stale: got %0d stale results, want 0", seen);
      end
      issueBeat(32'h0000_0040, 32'h0000_0002, 1'b0, 1'b0, lat);
      checks++;
      if (lat !== STAGES || sum !== 32'h42) begin
         failures++;
         $display("[TB] FAIL rstmid_next_beat: got lat=%0d sum=%h, want %0d/00000042", lat, sum, STAGES);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_carry();
      test_overflow();
      test_subtract();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor, the successor to the team's 32-bit ripple-carry adder. The carry chain is split into `STAGES` registered segments so that wide operands close timing. The block adds a valid/ready handshake with backpressure, a flush, a subtract mode and a signed-overflow flag. It sits between operand-issue logic and the writeback/result stream of the datapath.

## Interface
- `WIDTH`, default 32: operand and result width; must be divisible by `STAGES`.
- `STAGES`, default 4: number of pipeline segments; 1 ≤ `STAGES` ≤ `WIDTH`.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `flush`  input  1  synchronous; drops all in-flight operations.
- `in_valid`  input  1  operand beat valid.
- `in_ready`  output  1  block can accept an operand beat.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `c_in`  input  1  carry-in; used only when `sub`=0.
- `sub`  input  1  1 selects A−B, 0 selects A+B+c_in.
- `out_valid`  output  1  result beat valid.
- `out_ready`  input  1  downstream accepts the result beat.
- `sum`  output  WIDTH  result.
- `c_out`  output  1  carry out of bit WIDTH−1; for subtraction, 0 means borrow.
- `ovf`  output  1  signed overflow of the operation.

## Operation
- `CHUNK` = `WIDTH`/`STAGES`. Stage k (0..STAGES−1) adds bits [k·CHUNK +: CHUNK] of A and B' together with the carry registered out of stage k−1.
- Stage 0 carry-in is `c_in` when `sub`=0 and 1 when `sub`=1. B' = `sub` ? ~B : B.
- Not-yet-consumed operand chunks travel forward in skew registers alongside each stage. Completed sum chunks travel forward in deskew registers.
- The last stage produces:
  - `c_out`, the carry out of the MSB.
  - `ovf` = carry into MSB XOR carry out of MSB.
- Each stage holds one valid bit. A beat is accepted when `in_valid` && `in_ready`.
- The pipeline advances as a whole: `advance` = !`out_valid` || `out_ready`. `in_ready` = `advance`. There is no bubble collapsing.
- While `advance`=0, all stage registers hold and `sum`/`c_out`/`ovf` are stable.
- When `flush`=1, all valid bits clear at the next edge. No beat is accepted in a flush cycle: `in_ready` is forced to 0 that cycle. Data registers are don't-care after a flush.
- Results emerge strictly in acceptance order.

## Timing
- Latency: a beat accepted at edge t presents `out_valid`=1 after edge t+STAGES, provided there is no stall. Each stall cycle adds exactly one cycle.
- Throughput: one beat per cycle while `out_ready`=1.
- Reset (`rst_n`=0, asynchronous): all valid bits 0, `out_valid`=0, `sum`=0, `c_out`=0, `ovf`=0. `in_ready` reflects `advance`, so it is 1 during and after reset. Reset asserted mid-operation discards all in-flight beats.
- Simultaneous result consumption and new acceptance in one cycle is legal and required.
- `flush` and `out_ready` asserted together: the output beat is considered consumed, then the pipeline is emptied.
- `STAGES`=1 degenerates to a single registered adder with latency 1.

## Configuration
- `PIPELINED_ADDER_SAT_EN` defined:
  - On signed overflow, `sum` saturates to 0x7FF…F if A's sign bit is 0, otherwise to 0x800…0.
  - `ovf` still reports the overflow, and `c_out` still reports the raw carry.
- `PIPELINED_ADDER_SAT_EN` undefined:
  - `sum` wraps modulo 2^WIDTH.
  - The saturation mux and sign-tracking registers are absent.

## Test plan
All scenarios use WIDTH=32, STAGES=4.
- **Carry across all segments.** A=0xFFFFFFFF, B=0x00000001, c_in=0, sub=0 → 4 cycles later `sum`=0x00000000, `c_out`=1, `ovf`=0.
- **Signed overflow.** A=0x7FFFFFFF, B=0x00000001, sub=0 → `ovf`=1. `sum`=0x80000000 without the macro; `sum`=0x7FFFFFFF with `PIPELINED_ADDER_SAT_EN`.
- **Subtract with borrow.** A=5, B=7, sub=1, c_in=1 (c_in must be ignored) → `sum`=0xFFFFFFFE, `c_out`=0, `ovf`=0.
- **Backpressure.** Stream 8 beats of A=i, B=0x100·i back-to-back; drop `out_ready` for 3 cycles after the 2nd result.
  - `in_ready` is 0 for exactly those 3 cycles.
  - All 8 results (A+B) arrive in order with none lost or duplicated.
- **Flush and reset mid-operation.**
  - Accept 3 beats, then pulse `flush` for one cycle → no `out_valid` for those beats; a beat accepted the next cycle emerges 4 cycles later.
  - Repeat the same sequence with `rst_n` pulsed low asynchronously mid-cycle → outputs read 0 immediately.
